cubic_bezier_sampler: RTL and testbench
=======================================

Name: cubic_bezier_sampler

Overview:
- Initiator and consumer for the pipelined cubic Bezier evaluator (out = (a·t + b·t² + c·t³)/4, t = x/2^16, registered inputs, registered output).
- Accepts one motion segment (coefficients, parameter step, sample count) and drives the evaluator with a monotone parameter ramp.
- Collects the evaluator results and emits a backpressured stream of per-sample position deltas to the step generator.

Parameters:
- EVAL_LATENCY, 2, cycles from eval_x/eval_a/b/c driven to matching eval_out valid.
- DEPTH, 4, result FIFO entries; must be ≥ 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- seg_valid  in  1  segment offer.
- seg_ready  out  1  segment accept (IDLE only).
- seg_a  in  23  linear coefficient, signed.
- seg_b  in  23  quadratic coefficient, signed.
- seg_c  in  23  cubic coefficient, signed.
- seg_step  in  16  parameter increment, unsigned Q0.16.
- seg_count  in  16  number of samples.
- eval_x  out  17  parameter to evaluator.
- eval_a  out  23  coefficient to evaluator.
- eval_b  out  23  coefficient to evaluator.
- eval_c  out  23  coefficient to evaluator.
- eval_out  in  24  evaluator result, signed.
- delta_valid  out  1  delta available.
- delta_ready  in  1  consumer accept.
- delta  out  25  signed position delta.
- delta_last  out  1  final sample of segment.
- busy  out  1  segment in progress.

Behaviour:
Reset values:
- All outputs 0 except seg_ready = 1.
- FSM in IDLE; FIFO empty; tag pipe cleared.

FSM IDLE:
- seg_ready = 1; seg_valid & seg_ready accepts the segment.
- On accept: latch a/b/c onto eval_a/b/c, held constant for the whole segment; k = 0; prev = 0.
- seg_count = 0: accept, stay IDLE, emit nothing.
- seg_count > 0: go to ISSUE.

FSM ISSUE:
- Issue when k < count and credit = inflight + fifo_occupancy < DEPTH.
- Each issue: k ← k+1, and drive eval_x = {1'b0, x_k}:
  - x_k = 0xFFFF if k+1 == count;
  - otherwise x_k = min((k+1)·step, 0xFFFF), computed in 17+ bits and saturated.
- A 1-bit tag, marked last on the final issue, enters an EVAL_LATENCY-deep shift register.
- Non-issue cycles: eval_x holds its value and the tag bit is 0.
- After the final issue go to DRAIN.

FSM DRAIN:
- Wait until inflight == 0 and the FIFO is empty with its last entry accepted, then go to IDLE.
- busy = 1 in ISSUE and DRAIN.

Capture:
- When a tag exits the shift register, sample eval_out.
- Push delta = sext25(eval_out) − sext25(prev) and the last flag into the FIFO; then prev ← eval_out.
- The credit rule guarantees the push never overflows; overflow is an assertion failure.

Output:
- delta_valid = FIFO non-empty.
- delta and delta_last are stable while delta_valid & !delta_ready.
- Pop on delta_valid & delta_ready.
- A push and pop in the same cycle is legal at any occupancy.

Credit and throughput:
- Credit is counted pre-pop in the cycle.
- With delta_ready held at 1: one sample per cycle, and the first delta_valid appears EVAL_LATENCY+1 cycles after the first issue.

Reset mid-segment:
- Immediate abort; all state cleared; in-flight results discarded; no partial delta_last is produced.

Width and arithmetic:
- delta is 25 bits, so no overflow is possible.
- x bit 16 is always 0, so the parameter is always non-negative and < 1.0.

Test Plan:
- a=4000, b=c=0, step=0x4000, count=4, delta_ready=1 → eval_x 0x04000, 0x08000, 0x0C000, 0x0FFFF; eval_out 250, 500, 750, 999; deltas 250, 250, 250, 249 with delta_last on the 4th; back to IDLE (seg_ready=1) after the last pop.
- Saturation: a=4000, step=0x8000, count=3 → x 0x8000, 0xFFFF, 0xFFFF; deltas 500, 499, 0.
- Negative coefficient: a=−4000 (0x7FF060), count=1 → x=0xFFFF, eval_out=−1000, delta=−1000 (0x1FFFC18), delta_last=1.
- Backpressure: count=10, delta_ready=0 → issues stop after DEPTH samples and the FIFO holds them stable; releasing delta_ready delivers all 10 in order with none lost or duplicated (reference model comparison); seg_ready stays 0 throughout.
- count=0 segment then a count=1 segment back-to-back → the first produces no output and no busy; the second yields exactly one delta with delta_last.
- Assert rst_n low mid-ISSUE with 2 results in flight → delta_valid=0, seg_ready=1 and busy=0 immediately; no stale delta after release; the next segment starts from prev=0.

Source files
------------

// File: rtl/cubic_bezier_sampler.sv
// Cubic Bezier segment sampler.
// Accepts one motion segment, drives the pipelined Bezier evaluator with a
// monotone parameter ramp, and turns the evaluator results into a
// backpressured stream of signed per-sample position deltas.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   seg_valid/seg_ready             segment handshake (accepted only in idle)
//   seg_a/b/c                       signed linear/quadratic/cubic coefficients
//   seg_step                        unsigned Q0.16 parameter increment
//   seg_count                       number of samples in the segment
//   eval_x, eval_a/b/c              evaluator operands
//   eval_out                        signed evaluator result, EVAL_LATENCY after eval_x
//   delta_valid/delta_ready         delta stream handshake
//   delta, delta_last               signed position delta, final-sample flag
//   busy                            segment in progress
module cubic_bezier_sampler #(
  parameter int unsigned EVAL_LATENCY = 2,
  parameter int unsigned DEPTH        = 4   // result FIFO entries, at least 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seg_valid,
  output logic        seg_ready,
  input  logic [22:0] seg_a,
  input  logic [22:0] seg_b,
  input  logic [22:0] seg_c,
  input  logic [15:0] seg_step,
  input  logic [15:0] seg_count,
  output logic [16:0] eval_x,
  output logic [22:0] eval_a,
  output logic [22:0] eval_b,
  output logic [22:0] eval_c,
  input  logic [23:0] eval_out,
  output logic        delta_valid,
  input  logic        delta_ready,
  output logic [24:0] delta,
  output logic        delta_last,
  output logic        busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned CntW = $clog2(DEPTH + EVAL_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e state_q, state_d;

  logic [22:0] a_q, b_q, c_q;
  logic [15:0] step_q, count_q, k_q, x_hold_q;
  logic [23:0] prev_q;

  // Tag pipe shadows the evaluator: a set valid bit in the last stage means
  // eval_out currently carries the result of that issue.
  logic [EVAL_LATENCY-1:0] vld_pipe_q, last_pipe_q;

  // Result FIFO, entries are {last, delta}.
  logic [25:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q;

  logic            accept, issue, last_issue, push, pop;
  logic [16:0]     k_next;
  logic [32:0]     ramp;
  logic [15:0]     x_k;
  logic [CntW-1:0] used;
  logic [24:0]     delta_new;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Parameter ramp: the final sample is pinned to the end of the curve,
  // intermediate samples saturate just below 1.0.
  always_comb begin
    k_next     = {1'b0, k_q} + 17'd1;
    ramp       = 33'(k_next) * 33'(step_q);
    last_issue = (k_next == {1'b0, count_q});
    if (last_issue || (ramp > 33'h0_FFFF)) begin
      x_k = 16'hFFFF;
    end else begin
      x_k = ramp[15:0];
    end
  end

  // Credit: results in flight plus FIFO occupancy before this cycle's pop.
  always_comb begin
    used = CntW'(occ_q);
    for (int i = 0; i < int'(EVAL_LATENCY); i++) begin
      used = used + CntW'(vld_pipe_q[i]);
    end
  end

  assign delta_valid = (occ_q != '0);
  assign pop         = delta_valid & delta_ready;
  assign push        = vld_pipe_q[EVAL_LATENCY-1];
  assign delta_new   = {eval_out[23], eval_out} - {prev_q[23], prev_q};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        accept = seg_valid;
        if (seg_valid && (seg_count != 16'd0)) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if ((k_q < count_q) && (used < CntW'(DEPTH))) begin
          issue = 1'b1;
          if (last_issue) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave on the cycle the final entry is accepted.
        if ((vld_pipe_q == '0) &&
            ((occ_q == '0) || ((occ_q == OccW'(1)) && pop))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign seg_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign eval_x     = {1'b0, issue ? x_k : x_hold_q};
  assign eval_a     = a_q;
  assign eval_b     = b_q;
  assign eval_c     = c_q;
  assign delta      = mem_q[rd_ptr_q][24:0];
  assign delta_last = mem_q[rd_ptr_q][25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      step_q   <= '0;
      count_q  <= '0;
      k_q      <= '0;
      x_hold_q <= '0;
      prev_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= seg_a;
        b_q     <= seg_b;
        c_q     <= seg_c;
        step_q  <= seg_step;
        count_q <= seg_count;
        k_q     <= '0;
      end
      if (issue) begin
        k_q      <= k_next[15:0];
        x_hold_q <= x_k;
      end
      if (accept) begin
        prev_q <= '0;
      end else if (push) begin
        prev_q <= eval_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= issue;
      last_pipe_q[0] <= issue & last_issue;
      for (int i = 1; i < int'(EVAL_LATENCY); i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {last_pipe_q[EVAL_LATENCY-1], delta_new};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OccW'(1);
        2'b01:   occ_q <= occ_q - OccW'(1);
        default: ;
      endcase
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop) |-> (occ_q != OccW'(DEPTH)));

endmodule

// File: tb/tb_cubic_bezier_sampler.sv
// Bench for cubic_bezier_sampler: behavioural evaluator model plus directed
// segments with hand-computed deltas.
module tb_cubic_bezier_sampler;

  logic        clk;
  logic        rst_n;
  logic        seg_valid;
  logic        seg_ready;
  logic [22:0] seg_a, seg_b, seg_c;
  logic [15:0] seg_step, seg_count;
  logic [16:0] eval_x;
  logic [22:0] eval_a, eval_b, eval_c;
  logic [23:0] eval_out;
  logic        delta_valid;
  logic        delta_ready;
  logic [24:0] delta;
  logic        delta_last;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;
  int dq[$];
  logic lq[$];

  cubic_bezier_sampler #(
    .EVAL_LATENCY(2),
    .DEPTH       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .seg_a      (seg_a),
    .seg_b      (seg_b),
    .seg_c      (seg_c),
    .seg_step   (seg_step),
    .seg_count  (seg_count),
    .eval_x     (eval_x),
    .eval_a     (eval_a),
    .eval_b     (eval_b),
    .eval_c     (eval_c),
    .eval_out   (eval_out),
    .delta_valid(delta_valid),
    .delta_ready(delta_ready),
    .delta      (delta),
    .delta_last (delta_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out = floor((a*t + b*t^2 + c*t^3) / 4), t = x / 2^16
  function automatic logic signed [23:0] bez(input logic [16:0] x,
                                             input logic signed [22:0] a, b, c);
    logic signed [95:0] xs, av, bv, cv, num;
    xs  = $signed({79'd0, x});
    av  = a;
    bv  = b;
    cv  = c;
    num = ((av * xs) <<< 32) + ((bv * xs * xs) <<< 16) + (cv * xs * xs * xs);
    return 24'(num >>> 50);
  endfunction

  // Evaluator: registered inputs, registered output.
  logic [16:0]        ev_x_r;
  logic signed [22:0] ev_a_r, ev_b_r, ev_c_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_x_r   <= '0;
      ev_a_r   <= '0;
      ev_b_r   <= '0;
      ev_c_r   <= '0;
      eval_out <= '0;
    end else begin
      ev_x_r   <= eval_x;
      ev_a_r   <= eval_a;
      ev_b_r   <= eval_b;
      ev_c_r   <= eval_c;
      eval_out <= bez(ev_x_r, ev_a_r, ev_b_r, ev_c_r);
    end
  end

  always @(negedge clk) begin
    if (rst_n && delta_valid && delta_ready) begin
      dq.push_back(int'($signed(delta)));
      lq.push_back(delta_last);
    end
  end

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send_seg(input int a, input int b, input int c, input int step, input int cnt);
    seg_a     = 23'(a);
    seg_b     = 23'(b);
    seg_c     = 23'(c);
    seg_step  = 16'(step);
    seg_count = 16'(cnt);
    seg_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (seg_ready) break;
    end
    check_eq("seg_accept", seg_ready, 1);
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic wait_deltas(input int n);
    for (int i = 0; i < 200 && dq.size() < n; i++) @(negedge clk);
    check_eq("n_deltas", dq.size(), n);
  endtask

  function automatic logic [15:0] exp_x(input int k, input int step, input int cnt);
    longint p;
    if (k + 1 == cnt) return 16'hFFFF;
    p = longint'(k + 1) * longint'(step);
    return (p > 65535) ? 16'hFFFF : 16'(p);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    int   exp1[4];
    int   exp2[3];
    int   bp_exp[10];
    int   prev, cur, d0;
    logic sr_bad;

    rst_n       = 1'b1;
    seg_valid   = 1'b0;
    seg_a       = '0;
    seg_b       = '0;
    seg_c       = '0;
    seg_step    = '0;
    seg_count   = '0;
    delta_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_seg_ready", seg_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_delta_valid", delta_valid, 0);
    check_eq("rst_eval_x", eval_x, 0);
    check_eq("rst_delta", delta, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic ramp
    exp1 = '{250, 250, 250, 249};
    send_seg(4000, 0, 0, 'h4000, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("t1_x%0d", i), eval_x, (i == 3) ? 'hFFFF : (i + 1) * 'h4000);
      if (i == 0) check_eq("t1_busy", busy, 1);
      if (i == 0) check_eq("t1_seg_ready", seg_ready, 0);
      if (i == 2) check_eq("t1_early_valid", delta_valid, 0);
      if (i == 3) check_eq("t1_first_valid", delta_valid, 1);
    end
    wait_deltas(4);
    for (int i = 0; i < 4 && i < dq.size(); i++) begin
      check_eq($sformatf("t1_d%0d", i), dq[i], exp1[i]);
      check_eq($sformatf("t1_last%0d", i), lq[i], (i == 3) ? 1 : 0);
    end
    @(negedge clk);
    check_eq("t1_idle", seg_ready, 1);
    dq.delete();
    lq.delete();

    // Saturating ramp
    exp2 = '{500, 499, 0};
    @(posedge clk);
    #1;
    send_seg(4000, 0, 0, 'h8000, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("t2_x%0d", i), eval_x, (i == 0) ? 'h8000 : 'hFFFF);
    end
    wait_deltas(3);
    for (int i = 0; i < 3 && i < dq.size(); i++) begin
      check_eq($sformatf("t2_d%0d", i), dq[i], exp2[i]);
      check_eq($sformatf("t2_last%0d", i), lq[i], (i == 2) ? 1 : 0);
    end
    dq.delete();
    lq.delete();

    // Negative coefficient, single sample
    @(posedge clk);
    #1;
    send_seg(-4000, 0, 0, 'h1234, 1);
    wait_deltas(1);
    if (dq.size() > 0) begin
      check_eq("t3_d", dq[0], -1000);
      check_eq("t3_last", lq[0], 1);
    end
    dq.delete();
    lq.delete();

    // Backpressure, full cubic
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      cur       = int'(bez({1'b0, exp_x(k, 'h1000, 10)}, 23'sd4000, 23'sd1000, -23'sd2000));
      bp_exp[k] = cur - prev;
      prev      = cur;
    end
    delta_ready = 1'b0;
    @(posedge clk);
    #1;
    send_seg(4000, 1000, -2000, 'h1000, 10);
    sr_bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      sr_bad |= seg_ready;
    end
    check_eq("bp_valid", delta_valid, 1);
    check_eq("bp_x_stall", eval_x, 'h4000);
    check_eq("bp_eval_b", $signed(eval_b), 1000);
    check_eq("bp_eval_c", $signed(eval_c), -2000);
    check_eq("bp_head", $signed(delta), bp_exp[0]);
    check_eq("bp_head_last", delta_last, 0);
    d0 = int'($signed(delta));
    repeat (8) begin
      @(negedge clk);
      sr_bad |= seg_ready;
    end
    check_eq("bp_stable", $signed(delta), d0);
    check_eq("bp_x_still", eval_x, 'h4000);
    check_eq("bp_seg_ready_low", sr_bad, 0);
    @(posedge clk);
    #1;
    delta_ready = 1'b1;
    wait_deltas(10);
    for (int i = 0; i < 10 && i < dq.size(); i++) begin
      check_eq($sformatf("bp_d%0d", i), dq[i], bp_exp[i]);
      check_eq($sformatf("bp_last%0d", i), lq[i], (i == 9) ? 1 : 0);
    end
    repeat (4) @(negedge clk);
    check_eq("bp_no_extra", dq.size(), 10);
    dq.delete();
    lq.delete();

    // count=0 then count=1 back to back
    @(posedge clk);
    #1;
    seg_a     = 23'd4000;
    seg_b     = '0;
    seg_c     = '0;
    seg_step  = 16'h4000;
    seg_count = 16'd0;
    seg_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (seg_ready) break;
    end
    check_eq("t5_ready0", seg_ready, 1);
    @(posedge clk);
    #1;
    seg_count = 16'd1;
    @(negedge clk);
    check_eq("t5_busy0", busy, 0);
    check_eq("t5_ready1", seg_ready, 1);
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    wait_deltas(1);
    repeat (8) @(negedge clk);
    check_eq("t5_count", dq.size(), 1);
    if (dq.size() > 0) begin
      check_eq("t5_d", dq[0], 999);
      check_eq("t5_last", lq[0], 1);
    end
    dq.delete();
    lq.delete();

    // Reset with results in flight
    @(posedge clk);
    #1;
    send_seg(4000, 0, 0, 'h1000, 8);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid", delta_valid, 0);
    check_eq("t6_ready", seg_ready, 1);
    check_eq("t6_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t6_no_stale", dq.size(), 0);
    @(posedge clk);
    #1;
    send_seg(4000, 0, 0, 'h4000, 1);
    wait_deltas(1);
    if (dq.size() > 0) begin
      check_eq("t6_d", dq[0], 999);
      check_eq("t6_last", lq[0], 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
